// File: rtl/and_gate_pkg.sv
// Shared definitions for the and_gate stage: beat counter width,
// reduction flag layout and the counter increment helper.
package and_gate_pkg;

    localparam int COUNT_W = 16;

    // Reduction flags carried alongside the AND result in every beat.
    typedef struct packed {
        logic all_ones;
        logic none;
    } flags_t;

    function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] count);
        return count + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/and_gate_skid.sv
// Generic valid/ready register slice: a 2-entry skid buffer with a registered
// in_ready (SKID=1), or a single register stage with pass-through ready (SKID=0).
module and_gate_skid #(
    parameter int DATA_W = 1,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;

    assign out_valid = main_valid;
    assign out_data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic              ready_r;
            logic              in_fire;
            logic              out_fire;
            logic              load_skid;

            assign in_ready  = ready_r;
            assign in_fire   = in_valid & ready_r;
            assign out_fire  = main_valid & out_ready;
            assign load_skid = !skid_valid && in_fire && main_valid && !out_fire;

            // main_data is cleared on reset so the idle output reads 0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    skid_valid <= 1'b0;
                    ready_r    <= 1'b0;
                end else begin
                    if (skid_valid) begin
                        if (out_fire) begin
                            main_data  <= skid_data;
                            skid_valid <= 1'b0;
                        end
                    end else if (in_fire) begin
                        if (!main_valid || out_fire) begin
                            main_valid <= 1'b1;
                            main_data  <= in_data;
                        end else begin
                            skid_valid <= 1'b1;
                        end
                    end else if (out_fire) begin
                        main_valid <= 1'b0;
                    end
                    ready_r <= skid_valid ? out_fire : !load_skid;
                end
            end

            always_ff @(posedge clk) begin
                if (load_skid) begin
                    skid_data <= in_data;
                end
            end
        end else begin : g_single
            logic live;
            logic in_fire;

            // live holds in_ready low until the first edge after reset release
            assign in_ready = live & (~main_valid | out_ready);
            assign in_fire  = in_valid & in_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live       <= 1'b0;
                    main_valid <= 1'b0;
                    main_data  <= '0;
                end else begin
                    live <= 1'b1;
                    if (in_fire) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                    end else if (main_valid && out_ready) begin
                        main_valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/and_gate.sv
// Registered bitwise AND of two operand vectors with all-ones / all-zeros
// reduction flags, valid/ready flow control and a delivered-beat counter.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int SKID  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_all,
    output logic               out_none,
    output logic [COUNT_W-1:0] beat_count
);

    typedef struct packed {
        logic [WIDTH-1:0] value;
        flags_t           flags;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    function automatic beat_t make_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        beat_t r;
        r.value          = a & b;
        r.flags.all_ones = &r.value;
        r.flags.none     = ~|r.value;
        return r;
    endfunction

    beat_t             in_beat;
    beat_t             out_beat;
    logic [BEAT_W-1:0] out_bits;

    // Operands are only captured on acceptance, so unaccepted inputs never reach out
    assign in_beat = make_beat(in1, in2);

    and_gate_skid #(
        .DATA_W (BEAT_W),
        .SKID   (SKID)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bits)
    );

    assign out_beat = beat_t'(out_bits);
    assign out      = out_beat.value;
    assign out_all  = out_beat.flags.all_ones;
    assign out_none = out_beat.flags.none;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (out_valid && out_ready) begin
            beat_count <= next_count(beat_count);
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: WIDTH=8/SKID=1 and WIDTH=1/SKID=0 instances.
module tb_and_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_all, a_out_none;
    logic [7:0]  a_in1, a_in2, a_out;
    logic [15:0] a_beat_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_all, b_out_none;
    logic [0:0]  b_in1, b_in2, b_out;
    logic [15:0] b_beat_count;

    int n_vec  = 0;
    int n_fail = 0;

    // expected beats packed as {out, out_all, out_none}
    logic [9:0] exp_a[$];
    logic [2:0] exp_b[$];

    and_gate #(.WIDTH(8), .SKID(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in1(a_in1), .in2(a_in2),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
        .out_all(a_out_all), .out_none(a_out_none), .beat_count(a_beat_count)
    );

    and_gate #(.WIDTH(1), .SKID(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in1(b_in1), .in2(b_in2),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
        .out_all(b_out_all), .out_none(b_out_none), .beat_count(b_beat_count)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic void timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got no handshake, required one within bound", name);
    endfunction

    // Monitors: compare every delivered beat against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL a_unexpected_beat: got %0h, required no beat", a_out);
            end else begin
                check("a_beat", {22'b0, a_out, a_out_all, a_out_none}, {22'b0, exp_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL b_unexpected_beat: got %0h, required no beat", b_out);
            end else begin
                check("b_beat", {29'b0, b_out, b_out_all, b_out_none}, {29'b0, exp_b.pop_front()});
            end
        end
    end

    task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic [9:0] e, output int waits);
        a_in1 = x;
        a_in2 = y;
        a_in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!a_in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (a_in_ready) exp_a.push_back(e);
        else timeout("a_accept");
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic x, input logic y, input logic [2:0] e, output int waits);
        b_in1 = x;
        b_in2 = y;
        b_in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!b_in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (b_in_ready) exp_b.push_back(e);
        else timeout("b_accept");
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int k = 0;
        while (exp_a.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (exp_a.size() != 0) timeout("a_drain");
        @(posedge clk);
        #1;
    endtask

    task automatic drain_b();
        int k = 0;
        while (exp_b.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (exp_b.size() != 0) timeout("b_drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic x, y;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out", a_out, 0);
        check("rst_a_all", a_out_all, 0);
        check("rst_a_none", a_out_none, 0);
        check("rst_a_count", a_beat_count, 0);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        #2 rst_n = 1'b1;
        #1;
        check("rel_a_in_ready_pre", a_in_ready, 0);
        check("rel_b_in_ready_pre", b_in_ready, 0);
        @(posedge clk);
        #1;
        check("rel_a_in_ready", a_in_ready, 1);
        check("rel_b_in_ready", b_in_ready, 1);

        // WIDTH=1 truth table
        b_out_ready = 1'b1;
        send_b(1'b0, 1'b0, 3'b001, w);
        send_b(1'b0, 1'b1, 3'b001, w);
        send_b(1'b1, 1'b0, 3'b001, w);
        send_b(1'b1, 1'b1, 3'b110, w);
        check("b_tt_wait", w, 0);
        drain_b();
        check("b_count_tt", b_beat_count, 4);

        // SKID=0 stall, combinational ready, reload without bubble
        b_out_ready = 1'b0;
        send_b(1'b1, 1'b1, 3'b110, w);
        @(negedge clk);
        check("b_stall_in_ready", b_in_ready, 0);
        check("b_stall_out", b_out, 1);
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        #1;
        check("b_comb_in_ready", b_in_ready, 1);
        send_b(1'b1, 1'b0, 3'b001, w);
        check("b_nobubble_valid", b_out_valid, 1);
        check("b_nobubble_out", b_out, 0);
        drain_b();
        check("b_count_stall", b_beat_count, 6);

        // WIDTH=8 back-to-back
        a_out_ready = 1'b1;
        send_a(8'hF0, 8'h3C, {8'h30, 1'b0, 1'b0}, w);
        send_a(8'hFF, 8'hFF, {8'hFF, 1'b1, 1'b0}, w);
        check("a_b2b_wait", w, 0);
        check("a_b2b_valid", a_out_valid, 1);
        check("a_b2b_out", a_out, 8'hFF);
        drain_a();
        check("a_count_b2b", a_beat_count, 2);

        // backpressure into the skid register
        a_out_ready = 1'b0;
        send_a(8'hAA, 8'h0F, {8'h0A, 1'b0, 1'b0}, w);
        send_a(8'h55, 8'hFF, {8'h55, 1'b0, 1'b0}, w);
        a_in1 = 8'h11;
        a_in2 = 8'h11;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_bp_in_ready", a_in_ready, 0);
            check("a_bp_valid", a_out_valid, 1);
            check("a_bp_out", a_out, 8'h0A);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        drain_a();
        repeat (3) @(posedge clk);
        #1;
        check("a_count_bp", a_beat_count, 4);

        // asynchronous reset with a beat held at the output
        a_out_ready = 1'b0;
        send_a(8'hC3, 8'hFF, {8'hC3, 1'b0, 1'b0}, w);
        @(negedge clk);
        check("a_pre_rst_valid", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", a_out_valid, 0);
        check("arst_out", a_out, 0);
        check("arst_count", a_beat_count, 0);
        check("arst_in_ready", a_in_ready, 0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("arst_rel_in_ready_pre", a_in_ready, 0);
        @(posedge clk);
        #1;
        check("arst_rel_in_ready", a_in_ready, 1);
        check("arst_rel_valid", a_out_valid, 0);
        a_out_ready = 1'b1;
        send_a(8'h0F, 8'hF0, {8'h00, 1'b0, 1'b1}, w);
        drain_a();
        check("a_count_post_rst", a_beat_count, 1);

        // beat counter wrap on the WIDTH=1 instance
        b_out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            x = i[0];
            y = i[1];
            send_b(x, y, {x & y, x & y, ~(x & y)}, w);
        end
        drain_b();
        check("b_count_wrap", b_beat_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
Registered, parameterizable bitwise 2-input AND stage with a valid/ready handshake. Each accepted operand pair (in1, in2) produces one result beat: out = in1 & in2, plus reduction flags. It is a leaf datapath primitive used wherever a gated, flow-controlled AND of two operand vectors is needed.

Parameters:
WIDTH, 1, operand and result width in bits (>=1)
SKID, 1, 1 = 2-entry skid buffer (full throughput, registered in_ready); 0 = single register stage (in_ready combinational from out_ready)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept operands this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  WIDTH  in1 & in2 of the accepted pair
out_all  output  1  &(in1 & in2): all result bits 1
out_none  output  1  ~|(in1 & in2): all result bits 0
beat_count  output  16  number of results delivered (out_valid & out_ready), wraps 16'hFFFF -> 0

Behaviour:
- Reset (rst_n low, asynchronous, any time): out_valid=0, out=0, out_all=0, out_none=0, beat_count=0, skid buffer emptied; in_ready=0 while rst_n low, 1 from the first clk edge after deassertion. Pairs in flight at reset are discarded.
- Accept: transfer when in_valid & in_ready at the rising edge. Result computed at acceptance and registered; out_valid rises the next cycle (latency 1 cycle).
- Deliver: transfer when out_valid & out_ready. out, out_all, out_none stay stable while out_valid=1 and out_ready=0.
- SKID=1: main register + one skid register. in_ready = skid register empty (registered). Stall with main full and new pair accepted -> pair goes to skid. On drain, skid moves to main the same edge. Simultaneous accept and deliver with skid empty -> main reloads, out_valid stays 1, throughput 1 beat/cycle. Order strictly FIFO.
- SKID=0: in_ready = ~out_valid | out_ready. Simultaneous accept and deliver reloads main.
- in1/in2 are ignored when not accepted. X on unaccepted cycles must not propagate to out.
- Arithmetic: pure bitwise AND per bit, no carries. out_all and out_none are mutually exclusive except never both 1 (WIDTH>=1). For WIDTH=1, out_all = out and out_none = ~out.
- beat_count increments by 1 per delivered beat, modulo 2^16.
- When out_valid=0, out holds its last delivered value (0 after reset).

Decomposition:
- Shared package and_gate_pkg: COUNT_W=16 constant and a struct/typedef for the result beat {out, out_all, out_none}.
- One natural sub-module: and_gate_skid (generic valid/ready register slice, SKID selectable, payload width parameter). The top holds the AND/reduction logic and beat_count.

Test Plan:
- WIDTH=1 truth table, out_ready=1: pairs (0,0),(0,1),(1,0),(1,1) one per cycle -> out = 0,0,0,1 each one cycle after acceptance; out_all = 0,0,0,1; out_none = 1,1,1,0; beat_count ends at 4.
- WIDTH=8, back-to-back: in1=8'hF0,in2=8'h3C then 8'hFF,8'hFF -> out=8'h30 (out_all=0,out_none=0), then 8'hFF (out_all=1); one beat per cycle with SKID=1.
- Backpressure: out_ready=0 for 3 cycles while feeding 8'hAA&8'h0F then 8'h55&8'hFF -> first out=8'h0A held stable, second captured in skid, in_ready=0; release -> 8'h0A then 8'h55, in order, none lost or duplicated.
- Async reset mid-stream: assert rst_n=0 between clock edges with out_valid=1 -> out_valid, out, beat_count go to 0 immediately; in_ready=1 one edge after release.
- Counter wrap: deliver 65537 beats -> beat_count = 1.
- SKID=0 variant: out_ready=0 -> in_ready=0 combinationally. Simultaneous accept and deliver -> out updates with no bubble.
